// File: rtl/dmem_store_buffer_pkg.sv
// Shared types for the data-memory store buffer: FSM encoding, word-address width, buffer entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_pkg;

    localparam int WADDR_W = 30;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR      = 2'd1,
        ST_RD      = 2'd2,
        ST_RD_DONE = 2'd3
    } state_t;

    typedef logic [WADDR_W-1:0] waddr_t;

    typedef struct packed {
        waddr_t      addr;
        logic [31:0] data;
    } sb_entry_t;

endpackage

// File: rtl/dmem_store_buffer_if.sv
// Bundle of the MEM-stage port and the external memory req/ack port around the store buffer.
// Latency: n/a (wiring only).
// Backpressure: core side via core_stall, memory side via mem_req held until mem_ack.
interface dmem_store_buffer_if;

    logic [31:0] core_addr;
    logic        core_wen;
    logic        core_ren;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        core_stall;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        buf_empty;

    // The bridge: answers the core and masters the memory transaction.
    modport master (
        input  core_addr, core_wen, core_ren, core_wdata, mem_ack, mem_rdata,
        output core_rdata, core_stall, mem_req, mem_we, mem_addr, mem_wdata, buf_empty
    );

    // The surroundings: pipeline MEM stage plus the memory model.
    modport slave (
        output core_addr, core_wen, core_ren, core_wdata, mem_ack, mem_rdata,
        input  core_rdata, core_stall, mem_req, mem_we, mem_addr, mem_wdata, buf_empty
    );

endinterface

// File: rtl/dmem_store_buffer_sb_fifo.sv
// Circular store FIFO of {word addr, data} with a combinational youngest-match forward lookup.
// Latency: push visible to lookup/head the cycle after the edge; lookup is combinational.
// Backpressure: push ignored when full, pop ignored when empty; caller gates on full/count.
module sb_fifo
    import dmem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  sb_entry_t                  push_dat,
    input  logic                       pop,
    output sb_entry_t                  head_dat,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    input  waddr_t                     lookup_addr,
    output logic                       hit,
    output logic [31:0]                hit_dat
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t         entries [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     cnt;
    logic              push_ok;
    logic              pop_ok;

    assign full     = (cnt == CW'(DEPTH));
    assign push_ok  = push && !full;
    assign pop_ok   = pop && (cnt != '0);
    assign count    = cnt;
    assign head_dat = entries[head];

    // Pointer and occupancy bookkeeping; reset discards every buffered store.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push_ok) tail <= tail + PW'(1);
            if (pop_ok)  head <= head + PW'(1);
            if (push_ok && !pop_ok)      cnt <= cnt + CW'(1);
            else if (!push_ok && pop_ok) cnt <= cnt - CW'(1);
        end
    end

    // Entry storage; contents are qualified by cnt so they need no reset.
    always_ff @(posedge clk) begin
        if (push_ok) entries[tail] <= push_dat;
    end

    // Walk from oldest to youngest so the last match wins (youngest store forwards).
    always_comb begin
        logic [PW-1:0] idx;
        hit     = 1'b0;
        hit_dat = '0;
        idx     = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < cnt) && (entries[idx].addr == lookup_addr)) begin
                hit     = 1'b1;
                hit_dat = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/dmem_store_buffer.sv
// MEM-stage to multi-cycle memory bridge: single-cycle stores into a buffer, background in-order drain, load forwarding.
// Latency: store/hit 0 stall cycles; miss from IDLE stalls t..t+k, data at t+k+1; drain one store per ack latency + 1.
// Backpressure: core_stall on full-buffer store or load miss; memory request held stable until mem_ack.
module dmem_store_buffer
    import dmem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    dmem_store_buffer_if.master    bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t            state;
    state_t            next_state;
    sb_entry_t         head_dat;
    sb_entry_t         push_dat;
    logic [CW-1:0]     count;
    logic              full;
    logic              hit;
    logic [31:0]       hit_dat;
    waddr_t            word;
    logic              push;
    logic              pop;
    logic              load;
    logic              load_miss;

    logic              req_q;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rd_q;

    assign word      = bus.core_addr[31:2];
    assign push_dat  = '{addr: word, data: bus.core_wdata};
    assign push      = bus.core_wen && !full;
    assign load      = bus.core_ren && !bus.core_wen;
    assign load_miss = load && !hit;
    assign pop       = (state == ST_WR) && bus.mem_ack;

    sb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_dat    (push_dat),
        .pop         (pop),
        .head_dat    (head_dat),
        .count       (count),
        .full        (full),
        .lookup_addr (word),
        .hit         (hit),
        .hit_dat     (hit_dat)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Next state: a load miss beats draining; every transaction returns through IDLE.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (load_miss)            next_state = ST_RD;
                else if (count != '0)     next_state = ST_WR;
            end
            ST_WR:      if (bus.mem_ack) next_state = ST_IDLE;
            ST_RD:      if (bus.mem_ack) next_state = ST_RD_DONE;
            ST_RD_DONE: next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    // Core-facing outputs: stall on full store or unresolved miss, forward youngest hit or returned read.
    always_comb begin
        bus.core_stall = (bus.core_wen && full) || (load_miss && (state != ST_RD_DONE));
        bus.core_rdata = '0;
        if (hit)                        bus.core_rdata = hit_dat;
        else if (state == ST_RD_DONE)   bus.core_rdata = rd_q;
        bus.buf_empty  = (count == '0) && (state != ST_WR);
    end

    // Memory request registers: loaded when leaving IDLE, dropped on the ack edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load_miss) begin
                        req_q  <= 1'b1;
                        we_q   <= 1'b0;
                        addr_q <= {word, 2'b00};
                    end else if (count != '0) begin
                        req_q   <= 1'b1;
                        we_q    <= 1'b1;
                        addr_q  <= {head_dat.addr, 2'b00};
                        wdata_q <= head_dat.data;
                    end
                end
                ST_WR: if (bus.mem_ack) req_q <= 1'b0;
                ST_RD: begin
                    if (bus.mem_ack) begin
                        req_q <= 1'b0;
                        rd_q  <= bus.mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed self-checking bench for dmem_store_buffer with DEPTH = 4.
// Latency: n/a (testbench).
// Backpressure: memory acks are driven by hand at chosen cycles.
module tb_dmem_store_buffer;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    dmem_store_buffer_if bus ();

    dmem_store_buffer #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic wen, input logic ren, input logic [31:0] addr, input logic [31:0] wdata);
        bus.core_wen   = wen;
        bus.core_ren   = ren;
        bus.core_addr  = addr;
        bus.core_wdata = wdata;
        #1;
    endtask

    // Wait (bounded) for a write request, check it, then ack it for one cycle.
    task automatic drain_one(input string tag, input logic [31:0] exp_addr, input logic [31:0] exp_data);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (bus.mem_req === 1'b1 && bus.mem_we === 1'b1) found = 1'b1;
            else step();
        end
        chk({tag, "_seen"}, {31'd0, found}, 32'd1);
        if (found) begin
            chk({tag, "_addr"}, bus.mem_addr, exp_addr);
            chk({tag, "_data"}, bus.mem_wdata, exp_data);
            bus.mem_ack = 1'b1;
            step();
            bus.mem_ack = 1'b0;
            #1;
        end
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        rst            = 1'b1;
        bus.core_addr  = '0;
        bus.core_wen   = 1'b0;
        bus.core_ren   = 1'b0;
        bus.core_wdata = '0;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = '0;

        // Reset state
        #3;
        chk("rst_req",    {31'd0, bus.mem_req},    32'd0);
        chk("rst_we",     {31'd0, bus.mem_we},     32'd0);
        chk("rst_addr",   bus.mem_addr,            32'd0);
        chk("rst_wdata",  bus.mem_wdata,           32'd0);
        chk("rst_stall",  {31'd0, bus.core_stall}, 32'd0);
        chk("rst_rdata",  bus.core_rdata,          32'd0);
        chk("rst_empty",  {31'd0, bus.buf_empty},  32'd1);
        step();
        rst = 1'b0;
        step();

        // Single store drained with ack 3 cycles after req
        drive(1'b1, 1'b0, 32'h100, 32'hDEADBEEF);
        chk("t1_stall", {31'd0, bus.core_stall}, 32'd0);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        chk("t1_empty_busy", {31'd0, bus.buf_empty}, 32'd0);
        step();
        chk("t1_req",   {31'd0, bus.mem_req}, 32'd1);
        chk("t1_we",    {31'd0, bus.mem_we},  32'd1);
        chk("t1_addr",  bus.mem_addr,         32'h100);
        chk("t1_wdata", bus.mem_wdata,        32'hDEADBEEF);
        step();
        step();
        step();
        bus.mem_ack = 1'b1;
        #1;
        chk("t1_empty_ackcyc", {31'd0, bus.buf_empty}, 32'd0);
        step();
        bus.mem_ack = 1'b0;
        #1;
        chk("t1_empty_after", {31'd0, bus.buf_empty}, 32'd1);
        chk("t1_req_drop",    {31'd0, bus.mem_req},   32'd0);

        // Youngest-match forwarding
        drive(1'b1, 1'b0, 32'h10, 32'd1);
        chk("t2_st1_stall", {31'd0, bus.core_stall}, 32'd0);
        step();
        drive(1'b1, 1'b0, 32'h10, 32'd2);
        chk("t2_st2_stall", {31'd0, bus.core_stall}, 32'd0);
        step();
        drive(1'b0, 1'b1, 32'h12, 32'h0);
        chk("t2_fwd_rdata", bus.core_rdata,          32'd2);
        chk("t2_fwd_stall", {31'd0, bus.core_stall}, 32'd0);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        drain_one("t2_d1", 32'h10, 32'd1);
        drain_one("t2_d2", 32'h10, 32'd2);
        chk("t2_empty", {31'd0, bus.buf_empty}, 32'd1);

        // Full buffer: 5th store stalls until one pop, accepted the cycle after
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'h300 + 32'(4 * i), 32'h11 + 32'(i));
            chk($sformatf("t3_st%0d_stall", i), {31'd0, bus.core_stall}, 32'd0);
            step();
        end
        drive(1'b1, 1'b0, 32'h310, 32'h15);
        chk("t3_full_stall", {31'd0, bus.core_stall}, 32'd1);
        step();
        chk("t3_full_hold", {31'd0, bus.core_stall}, 32'd1);
        bus.mem_ack = 1'b1;
        #1;
        chk("t3_popcyc_stall", {31'd0, bus.core_stall}, 32'd1);
        chk("t3_first_wdata",  bus.mem_wdata,           32'h11);
        step();
        bus.mem_ack = 1'b0;
        #1;
        chk("t3_accept_stall", {31'd0, bus.core_stall}, 32'd0);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        drain_one("t3_d2", 32'h304, 32'h12);
        drain_one("t3_d3", 32'h308, 32'h13);
        drain_one("t3_d4", 32'h30C, 32'h14);
        drain_one("t3_d5", 32'h310, 32'h15);
        chk("t3_empty", {31'd0, bus.buf_empty}, 32'd1);

        // Load miss from IDLE, ack at k = 2
        drive(1'b0, 1'b1, 32'h200, 32'h0);
        chk("t4_stall_t0", {31'd0, bus.core_stall}, 32'd1);
        step();
        chk("t4_req",      {31'd0, bus.mem_req},    32'd1);
        chk("t4_we",       {31'd0, bus.mem_we},     32'd0);
        chk("t4_addr",     bus.mem_addr,            32'h200);
        chk("t4_stall_t1", {31'd0, bus.core_stall}, 32'd1);
        step();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h12345678;
        #1;
        chk("t4_stall_t2", {31'd0, bus.core_stall}, 32'd1);
        step();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        #1;
        chk("t4_stall_t3", {31'd0, bus.core_stall}, 32'd0);
        chk("t4_rdata",    bus.core_rdata,          32'h12345678);
        chk("t4_req_drop", {31'd0, bus.mem_req},    32'd0);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        chk("t4_rdata_idle", bus.core_rdata, 32'd0);

        // Load miss while a write is in flight
        drive(1'b1, 1'b0, 32'h400, 32'hA1);
        step();
        drive(1'b1, 1'b0, 32'h404, 32'hA2);
        step();
        drive(1'b0, 1'b1, 32'h500, 32'h0);
        chk("t5_stall_wr", {31'd0, bus.core_stall}, 32'd1);
        chk("t5_wr_we",    {31'd0, bus.mem_we},     32'd1);
        chk("t5_wr_addr",  bus.mem_addr,            32'h400);
        step();
        bus.mem_ack = 1'b1;
        #1;
        chk("t5_wr_wdata", bus.mem_wdata, 32'hA1);
        step();
        bus.mem_ack = 1'b0;
        #1;
        chk("t5_idle_req",   {31'd0, bus.mem_req},    32'd0);
        chk("t5_idle_stall", {31'd0, bus.core_stall}, 32'd1);
        step();
        chk("t5_rd_req",  {31'd0, bus.mem_req}, 32'd1);
        chk("t5_rd_we",   {31'd0, bus.mem_we},  32'd0);
        chk("t5_rd_addr", bus.mem_addr,         32'h500);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hCAFE0500;
        step();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        #1;
        chk("t5_done_stall", {31'd0, bus.core_stall}, 32'd0);
        chk("t5_done_rdata", bus.core_rdata,          32'hCAFE0500);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        drain_one("t5_d2", 32'h404, 32'hA2);

        // Reset while in RD with two stores buffered
        drive(1'b1, 1'b0, 32'h600, 32'hB0);
        step();
        drive(1'b1, 1'b0, 32'h604, 32'hB1);
        step();
        drive(1'b1, 1'b0, 32'h608, 32'hB2);
        step();
        drive(1'b0, 1'b1, 32'h700, 32'h0);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        step();
        chk("t6_rd_req", {31'd0, bus.mem_req}, 32'd1);
        chk("t6_rd_we",  {31'd0, bus.mem_we},  32'd0);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_req_drop", {31'd0, bus.mem_req},   32'd0);
        chk("t6_empty",    {31'd0, bus.buf_empty}, 32'd1);
        step();
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t6_no_req_%0d", i), {31'd0, bus.mem_req}, 32'd0);
            step();
        end
        chk("t6_empty_after", {31'd0, bus.buf_empty}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
